// File: rtl/dsp_filters_pkg.sv
// Shared definitions for the averaging-filter / decimator chain.
// Holds default widths, decimation bounds and the accumulator-width helper.
package dsp_filters_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int LOG2_DECIM_MIN = 1;
  localparam int LOG2_DECIM_MAX = 6;

  // Adding D = 2^l2d signed samples needs l2d extra bits of headroom.
  function automatic int acc_width(input int dw, input int l2d);
    return dw + l2d;
  endfunction

endpackage

// File: rtl/decim_phase_counter.sv
// Window phase counter for the boxcar decimator.
// Tracks the sample index within the current window and flags the last slot.
module decim_phase_counter
  import dsp_filters_pkg::*;
#(
  parameter int LOG2_DECIM = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ce,
  input  logic                  i_sync,
  output logic [LOG2_DECIM-1:0] o_phase,
  output logic                  o_last
);

  localparam logic [LOG2_DECIM-1:0] LAST_PHASE = {LOG2_DECIM{1'b1}};

  logic [LOG2_DECIM-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
    end else if (i_sync) begin
      // A qualified sync sample opens the new window as its slot 0.
      r_phase <= i_ce ? LOG2_DECIM'(1) : '0;
    end else if (i_ce) begin
      r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + LOG2_DECIM'(1);
    end
  end

  assign o_phase = r_phase;
  assign o_last  = (r_phase == LAST_PHASE);

endmodule

// File: rtl/boxcar_decimator.sv
// Integrate-and-dump decimator: averages each group of 2^LOG2_DECIM samples.
// Define DECIM_ROUND_EN for round-half-up output; default build truncates (floor).
module boxcar_decimator
  import dsp_filters_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_DECIM = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_ce,
  input  logic                         i_sync,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_ce
);

  localparam int AW = acc_width(DATA_WIDTH, LOG2_DECIM);

  if (LOG2_DECIM < LOG2_DECIM_MIN || LOG2_DECIM > LOG2_DECIM_MAX) begin : g_bad_decim
    $error("boxcar_decimator: LOG2_DECIM out of range");
  end

  logic [LOG2_DECIM-1:0] w_unused_phase;
  logic                  w_last;
  logic                  w_dump;
  logic signed [AW-1:0]  w_din_ext;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_sum_rnd;
  logic signed [AW-1:0]  r_acc;

  decim_phase_counter #(
    .LOG2_DECIM(LOG2_DECIM)
  ) u_phase (
    .clk    (clk),
    .reset  (reset),
    .i_ce   (i_ce),
    .i_sync (i_sync),
    .o_phase(w_unused_phase),
    .o_last (w_last)
  );

  assign w_din_ext = {{LOG2_DECIM{data_in[DATA_WIDTH-1]}}, data_in};
  assign w_sum     = r_acc + w_din_ext;
  assign w_dump    = i_ce && !i_sync && w_last;

`ifdef DECIM_ROUND_EN
  // Max D*127 + D/2 still fits in AW signed bits, so no guard bit is needed.
  localparam int RND_HALF = 1 << (LOG2_DECIM - 1);
  assign w_sum_rnd = w_sum + AW'(RND_HALF);
`else
  assign w_sum_rnd = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_sync) begin
      r_acc <= i_ce ? w_din_ext : '0;
    end else if (i_ce) begin
      r_acc <= w_last ? '0 : w_sum;
    end
  end

  // Taking the top DATA_WIDTH bits is the arithmetic shift by LOG2_DECIM.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      o_ce     <= 1'b0;
    end else begin
      o_ce <= w_dump;
      if (w_dump) data_out <= w_sum_rnd[AW-1:LOG2_DECIM];
    end
  end

endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Integrate-and-dump decimator that sits directly downstream of the two-tap averaging filter. It consumes the filter's `o_ce`/`data_out` stream and sums each group of 2^LOG2_DECIM qualified samples. Each completed group yields one averaged, down-sampled output with its own one-cycle `o_ce` strobe, so the output rate is reduced by the decimation factor.

## Interface
- `DATA_WIDTH`, default 8: signed sample width, for both input and output.
- `LOG2_DECIM`, default 2: log2 of the decimation factor D. Legal range is 1..6, so default D = 4.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `reset`  input  1: one clock; reset is synchronous and active-high.
- `i_ce`  input  1: input sample qualifier; connects to the upstream filter's `o_ce`.
- `i_sync`  input  1: window realignment request.
- `data_in`  input  DATA_WIDTH: signed input sample, valid only when `i_ce`=1.
- `data_out`  output  DATA_WIDTH: signed decimated sample, registered.
- `o_ce`  output  1: one-cycle strobe marking a new `data_out`.

## Operation
- **Internal state**
  - Signed accumulator `acc`, AW = DATA_WIDTH+LOG2_DECIM bits.
  - Phase counter `phase`, range 0..D-1.
- **Reset** (highest priority, every cycle):
  - `acc`=0, `phase`=0.
  - `data_out`=0, `o_ce`=0.
- **`i_ce`=1, `i_sync`=0, `phase`<D-1:**
  - `acc` += sign-extended `data_in`.
  - `phase`++.
  - `o_ce`=0.
- **`i_ce`=1, `i_sync`=0, `phase`=D-1:**
  - sum = `acc` + `data_in`.
  - `data_out` <= sum >>> LOG2_DECIM (arithmetic shift).
  - `o_ce` <= 1.
  - `acc` <= 0, `phase` <= 0.
- **`i_ce`=0:**
  - `acc` and `phase` hold.
  - `o_ce` <= 0.
  - `data_out` holds; `data_in` is ignored.
- **`i_sync`=1, `i_ce`=1:**
  - The partial window is discarded.
  - The current sample becomes the first sample of a new window: `acc` <= `data_in`, `phase` <= 1.
  - No output is produced.
- **`i_sync`=1, `i_ce`=0:**
  - `acc` <= 0, `phase` <= 0.
  - No output is produced.
- **Arithmetic:** AW bits hold D samples exactly, so no overflow and no saturation logic. The output always lies within [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Continuous stream:** back-to-back `i_ce` every cycle is supported. Output strobes are then exactly D cycles apart.

## Timing
- **Latency:** `o_ce` and the new `data_out` appear on the clock edge that samples the D-th `i_ce`. They are visible to the next stage one cycle later, i.e. registered, 1-cycle latency.
- **Strobe width:** `o_ce` is never high for two consecutive cycles, because D ≥ 2.
- **Reset mid-window:** the partial sum is lost, and the next window starts at the first `i_ce` after reset deasserts.
- **Reset coincident with the D-th sample:** reset wins and no output is produced.

## Configuration
- **`DECIM_ROUND_EN` defined:**
  - Output = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM, i.e. round half toward +inf.
  - The AW-bit adder cannot overflow: max D·127 + D/2 < D·128.
- **`DECIM_ROUND_EN` undefined:** output = sum >>> LOG2_DECIM, i.e. floor / truncate toward -inf. This matches the upstream filter's truncation.

## Structure
- **Shared package `dsp_filters_pkg`:**
  - Default DATA_WIDTH.
  - AW calculation function.
  - LOG2_DECIM legality bounds.
- **Sub-module `decim_phase_counter`:**
  - Parameter LOG2_DECIM; ports `clk`, `reset`, `i_ce`, `i_sync`, `o_phase`, `o_last`.
  - Owns the phase counter, realignment, and terminal-count detection.
- **Top level:** contains the accumulator, rounding, and output registers.

## Test plan
All cases use DATA_WIDTH=8, LOG2_DECIM=2.
- **Reset:** hold `reset` 2 cycles with random `data_in`/`i_ce` -> `data_out`=0, `o_ce`=0. The first output after release requires 4 fresh samples.
- **Constant stream:** `i_ce` every cycle, `data_in`=10 ×8 -> `o_ce` pulses twice, 4 cycles apart, `data_out`=10 each time.
- **Rounding:**
  - Inputs 1,2,2,2 -> 1 (truncate) / 2 (`DECIM_ROUND_EN`).
  - Inputs -1,-2,-2,-2 -> -2 in both modes.
- **Extremes:**
  - 4×127 -> 127.
  - 4×-128 -> -128.
  - No wrap in either mode.
- **Gaps and sync:**
  - Samples 100,100,100 with idle cycles between them, then `i_sync`+`i_ce` with 8, then 8,8,8 -> one output, `data_out`=8.
  - No output from the 100s.
  - `data_in` changes while `i_ce`=0 are ignored.
- **Reset mid-window:** 20,20, then `reset` for 1 cycle, then 4,4,4,4 -> single `o_ce`, `data_out`=4.
